// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//
// Generates NUM_CLOCKS independent clock-enable channels from one reference
// clock. Each channel runs a modulo-div counter and produces a one-cycle tick
// at a programmable phase plus a divided square wave (high for the first
// ceil(div/2) counts). A valid/ready port reprograms one channel at a time.
// The new setting is held until the target channel reaches the end of its
// current period, so its outputs never show a truncated period. The control
// FSM then re-settles before reporting lock.
//
// Ports
//   refclk     in   reference clock, all logic on its rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_valid  in   reconfiguration request present
//   cfg_ready  out  request can be accepted (SETTLE / LOCKED)
//   cfg_sel    in   target channel index (out-of-range selects no channel)
//   cfg_div    in   new divisor (0 is treated as 1)
//   cfg_phase  in   new tick phase (clamped to divisor-1)
//   tick       out  per-channel one-cycle enable pulse
//   outclk     out  per-channel divided square wave
//   locked     out  every channel is running a settled configuration
// -----------------------------------------------------------------------------
module clk_enable_gen #(
  parameter int  NUM_CLOCKS  = 2,
  parameter int  DIV_WIDTH   = 8,
  parameter int  DIV_INIT    = 2,
  parameter int  LOCK_CYCLES = 16,
  localparam int SEL_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DIV_WIDTH-1:0]  cfg_phase,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int SETTLE_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);
  // A zero reset divisor would leave the counter without a wrap point.
  localparam logic [DIV_WIDTH-1:0] DIV_RST     = DIV_WIDTH'((DIV_INIT < 1) ? 1 : DIV_INIT);
  localparam logic [SEL_W:0]       SEL_LIMIT   = (SEL_W + 1)'(NUM_CLOCKS);

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [SEL_W-1:0]      pend_sel_q, pend_sel_d;
  logic [DIV_WIDTH-1:0]  pend_div_q, pend_div_d;
  logic [DIV_WIDTH-1:0]  pend_phase_q, pend_phase_d;
  logic                  ready_q, ready_d;
  logic                  locked_q, locked_d;

  logic                  xfer;
  logic                  pending;
  logic                  sel_bad;
  logic                  pend_done;
  logic [NUM_CLOCKS-1:0] apply_hit;
  logic [DIV_WIDTH-1:0]  cap_div;
  logic [DIV_WIDTH-1:0]  cap_phase;

  assign xfer    = cfg_valid && ready_q;
  assign pending = (state_q == ST_PENDING);
  // An out-of-range target has no wrap to wait for, so the request retires
  // on its first PENDING cycle without touching any channel.
  assign sel_bad   = ({1'b0, pend_sel_q} >= SEL_LIMIT);
  assign pend_done = sel_bad || (|apply_hit);

  // Normalise the request at capture time so the channels only ever see a
  // legal divisor and an in-range phase.
  always_comb begin
    cap_div   = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
    cap_phase = (cfg_phase >= cap_div) ? (cap_div - DIV_WIDTH'(1)) : cfg_phase;
  end

  // ---------------------------------------------------------------------------
  // Per-channel counter and output registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLOCKS; gi++) begin : g_ch
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic [DIV_WIDTH-1:0] div_q, div_d;
      logic [DIV_WIDTH-1:0] phase_q, phase_d;
      logic                 tick_q, tick_d;
      logic                 outclk_q, outclk_d;
      logic [DIV_WIDTH:0]   high_len;
      logic                 at_wrap;
      logic                 do_apply;

      assign at_wrap  = (cnt_q == (div_q - DIV_WIDTH'(1)));
      assign do_apply = pending && (pend_sel_q == SEL_W'(gi)) && at_wrap;
      assign apply_hit[gi] = do_apply;

      always_comb begin
        // Applying a new setting coincides with a wrap, so the counter
        // restarts at 0 under the new divisor on the following cycle.
        cnt_d   = at_wrap ? '0 : (cnt_q + DIV_WIDTH'(1));
        div_d   = div_q;
        phase_d = phase_q;
        if (do_apply) begin
          div_d   = pend_div_q;
          phase_d = pend_phase_q;
        end
        // ceil(div/2), computed one bit wider so div = max does not overflow
        high_len = ({1'b0, div_q} + (DIV_WIDTH + 1)'(1)) >> 1;
        tick_d   = (cnt_q == phase_q);
        outclk_d = ({1'b0, cnt_q} < high_len);
      end

      always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q    <= '0;
          div_q    <= DIV_RST;
          phase_q  <= '0;
          tick_q   <= 1'b0;
          outclk_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          div_q    <= div_d;
          phase_q  <= phase_d;
          tick_q   <= tick_d;
          outclk_q <= outclk_d;
        end
      end

      assign tick[gi]   = tick_q;
      assign outclk[gi] = outclk_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SETTLE;
      settle_q     <= '0;
      pend_sel_q   <= '0;
      pend_div_q   <= '0;
      pend_phase_q <= '0;
      ready_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      pend_sel_q   <= pend_sel_d;
      pend_div_q   <= pend_div_d;
      pend_phase_q <= pend_phase_d;
      ready_q      <= ready_d;
      locked_q     <= locked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    pend_sel_d   = pend_sel_q;
    pend_div_d   = pend_div_q;
    pend_phase_d = pend_phase_q;

    if (xfer) begin
      pend_sel_d   = cfg_sel;
      pend_div_d   = cap_div;
      pend_phase_d = cap_phase;
    end

    case (state_q)
      ST_SETTLE: begin
        if (xfer) begin
          state_d = ST_PENDING;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_LOCKED;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (pend_done) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: outputs
  // Decoded from the next state and registered, so ready/locked track the
  // state register exactly while still reading 0 throughout reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d  = (state_d != ST_PENDING);
    locked_d = (state_d == ST_LOCKED);
  end

  assign cfg_ready = ready_q;
  assign locked    = locked_q;

endmodule
